// File: rtl/audio_mix_pkg.sv
// Shared types and helpers for the audio effect mixer: FSM state encoding,
// source-index width derivation and the dry source index.
package audio_mix_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC_L = 2'd1,
    CALC_R = 2'd2,
    OUT    = 2'd3
  } mix_state_t;

  localparam int SRC_DRY = 0;

  // Source index covers dry plus every effect input.
  function automatic int src_width(input int n_fx);
    return (n_fx < 1) ? 1 : $clog2(n_fx + 1);
  endfunction

endpackage

// File: rtl/audio_mix_sel_sync.sv
// Two-flop synchroniser for the raw effect-select switches, with an optional
// stability filter enabled by AUDIO_MIX_DEBOUNCE_EN.
module audio_mix_sel_sync #(
  parameter int N               = 3,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic         CLOCK_50,
  input  logic         rst,
  input  logic [N-1:0] sel,
  output logic [N-1:0] sel_stable
);

  logic [N-1:0] sync1, sync2;

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sel;
      sync2 <= sync1;
    end
  end

`ifdef AUDIO_MIX_DEBOUNCE_EN
  logic [N-1:0] cand;
  logic [19:0]  deb_cnt;

  // Down-counter reloads on every change; the candidate is promoted only at terminal count.
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      cand       <= '0;
      deb_cnt    <= '0;
      sel_stable <= '0;
    end else begin
      cand <= sync2;
      if (sync2 != cand)
        deb_cnt <= 20'(DEBOUNCE_CYCLES - 1);
      else if (deb_cnt != 20'd0)
        deb_cnt <= deb_cnt - 20'd1;
      else
        sel_stable <= cand;
    end
  end
`else
  assign sel_stable = sync2;
`endif

endmodule

// File: rtl/audio_effect_mixer.sv
// Stereo dry/effect selector with linear crossfade on source change.
// Optional select debounce: AUDIO_MIX_DEBOUNCE_EN.
//
// state  | meaning
// IDLE   | wait for sample_valid, capture old/new samples, maybe start fade
// CALC_L | mix left channel through the shared multiply-add
// CALC_R | mix right channel, register mix_out, pulse out_valid
// OUT    | advance fade counter, end fade on last step
module audio_effect_mixer
  import audio_mix_pkg::*;
#(
  parameter int W               = 16,
  parameter int N_FX            = 3,
  parameter int FADE_LOG2       = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  localparam int SRC_W          = src_width(N_FX)
) (
  input  logic                  CLOCK_50,
  input  logic                  rst,
  input  logic [N_FX-1:0]       sel,
  input  logic                  sample_valid,
  input  logic [2*W-1:0]        dry_in,
  input  logic [N_FX*2*W-1:0]   fx_in,
  output logic [2*W-1:0]        mix_out,
  output logic                  out_valid,
  output logic [SRC_W-1:0]      active_src,
  output logic                  fading,
  output logic                  overrun
);

  localparam int F  = 1 << FADE_LOG2;
  localparam int GW = FADE_LOG2 + 1;
  localparam int PW = W + FADE_LOG2 + 2;

  mix_state_t           state;
  logic [N_FX-1:0]      sel_stable;
  logic [SRC_W-1:0]     req_src, cur_src, old_src;
  logic [FADE_LOG2-1:0] fade_cnt;
  logic [2*W-1:0]       old_smp, new_smp;
  logic signed [W-1:0]  res_l, mix_y, ch_old, ch_new;
  logic [GW-1:0]        g_new, g_old;
  logic signed [PW-1:0] acc;

  audio_mix_sel_sync #(
    .N               (N_FX),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sel_sync (
    .CLOCK_50   (CLOCK_50),
    .rst        (rst),
    .sel        (sel),
    .sel_stable (sel_stable)
  );

  function automatic logic [2*W-1:0] pick_src(input logic [SRC_W-1:0] s,
                                              input logic [2*W-1:0] dry,
                                              input logic [N_FX*2*W-1:0] fx);
    pick_src = dry;
    for (int k = 0; k < N_FX; k++)
      if (s == SRC_W'(k + 1)) pick_src = fx[k*2*W +: 2*W];
  endfunction

  // Only a one-hot select picks an effect; anything else falls back to dry.
  always_comb begin
    req_src = SRC_W'(SRC_DRY);
    if (sel_stable != '0 && (sel_stable & (sel_stable - 1'b1)) == '0)
      for (int k = 0; k < N_FX; k++)
        if (sel_stable[k]) req_src = SRC_W'(k + 1);
  end

  always_comb begin
    g_new  = fading ? (GW'(fade_cnt) + 1'b1) : GW'(F);
    g_old  = GW'(F) - g_new;
    ch_old = (state == CALC_L) ? old_smp[2*W-1:W] : old_smp[W-1:0];
    ch_new = (state == CALC_L) ? new_smp[2*W-1:W] : new_smp[W-1:0];
    acc    = PW'(ch_old) * PW'($signed({1'b0, g_old}))
           + PW'(ch_new) * PW'($signed({1'b0, g_new}));
    mix_y  = W'(acc >>> FADE_LOG2);
  end

  assign active_src = cur_src;

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur_src   <= SRC_W'(SRC_DRY);
      old_src   <= SRC_W'(SRC_DRY);
      fade_cnt  <= '0;
      fading    <= 1'b0;
      old_smp   <= '0;
      new_smp   <= '0;
      res_l     <= '0;
      mix_out   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (sample_valid && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            // The capturing sample is already the first step of a new fade.
            if (!fading && req_src != cur_src) begin
              old_src  <= cur_src;
              cur_src  <= req_src;
              fade_cnt <= '0;
              fading   <= 1'b1;
              old_smp  <= pick_src(cur_src, dry_in, fx_in);
              new_smp  <= pick_src(req_src, dry_in, fx_in);
            end else begin
              old_smp  <= pick_src(old_src, dry_in, fx_in);
              new_smp  <= pick_src(cur_src, dry_in, fx_in);
            end
            state <= CALC_L;
          end
        end
        CALC_L: begin
          res_l <= mix_y;
          state <= CALC_R;
        end
        CALC_R: begin
          mix_out   <= {res_l, mix_y};
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (fading) begin
            if (fade_cnt == FADE_LOG2'(F - 1)) begin
              fading   <= 1'b0;
              fade_cnt <= '0;
            end else begin
              fade_cnt <= fade_cnt + 1'b1;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
